rpi_strobe_rx: RTL
==================

Name: rpi_strobe_rx

Overview:
- Receive path from the Raspberry Pi into the FPGA.
- The Pi drives a slow strobe clock, a data line and an enable line on GPIO. This block synchronises them into the 50 MHz domain and samples data on each strobe rising edge.
- It assembles MSB-first words and presents them on a valid/ready interface to downstream audio logic.
- It is the Pi-to-FPGA complement of the FPGA-to-Pi interrupt/clock generator.

Parameters:
- WORD_W, 16, bits per received word (2..32).
- SYNC_STAGES, 2, flip-flop stages on each Pi input (2..4).
- TIMEOUT_CYC, 1024, clk_in cycles with no strobe edge before a partial word is abandoned (>=4).

Ports:
- clk_in  input  1  50 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- rpi_clk  input  1  Pi strobe, asynchronous to clk_in.
- rpi_data  input  1  Pi serial data, asynchronous; stable around the rpi_clk rising edge.
- rpi_enable  input  1  Pi frame enable, asynchronous, active high.
- word_out  output  WORD_W  last completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when high together with word_valid.
- overflow  output  1  sticky: a completed word was dropped.
- overflow_clr  input  1  synchronous clear of overflow.
- frame_err  output  1  one-cycle pulse: partial word discarded by timeout or enable drop.
- busy  output  1  high while 1..WORD_W-1 bits are held.

Behaviour:
- Reset (async, reset_n=0) clears:
  - all sync flops, shift register and bit counter;
  - timeout counter and state (DISABLED);
  - word_out, word_valid, overflow, frame_err, busy, all to 0.
- Synchronisation:
  - rpi_clk, rpi_data and rpi_enable each pass through SYNC_STAGES flops.
  - A registered copy of synced rpi_clk gives rise = sync & ~prev. Only rising edges are used.
- State machine:
  - DISABLED: synced enable=0. Shifter and counter held at 0. Goes to ARMED when synced enable=1.
  - ARMED: 0 bits held. On rise, shift in data, count=1, go to RECV. If WORD_W would be reached, complete immediately (only meaningful for WORD_W=1, which is disallowed).
  - RECV: each rise shifts left, inserting data at the LSB, and count increments.
  - Word completion: when count reaches WORD_W, the word is loaded into word_out on that same clock edge. Count resets to 0 and the state returns to ARMED.
- Latency: word_valid is high in the cycle after the clk_in edge that registers the final rise, i.e. SYNC_STAGES+2 cycles after the pin edge.
- Output handshake:
  - word_valid stays high until a cycle with word_ready=1, then clears on the next edge.
  - word_out is stable while word_valid=1.
- Completion while word_valid=1 and word_ready=0:
  - new word dropped;
  - word_out unchanged;
  - overflow set.
- Completion in the same cycle as word_ready=1 with word_valid=1: the new word is loaded, word_valid stays 1, and there is no overflow.
- overflow:
  - Cleared by overflow_clr.
  - If set and clear occur in the same cycle, set wins.
- Enable drop:
  - Synced enable falling in RECV: partial discarded, frame_err pulses one cycle, go to DISABLED.
  - Falling in ARMED: no pulse.
  - Enable falls in the same cycle as a rise: enable wins, no shift, and a partial is discarded with frame_err.
- Timeout:
  - In RECV a counter counts cycles without a rise and is reset on each rise.
  - Reaching TIMEOUT_CYC: partial discarded, frame_err pulses, go to ARMED.
  - The counter is idle in ARMED and DISABLED.
- busy = (state==RECV).
- A completed word already in word_out is unaffected by enable drop or timeout.
- Reset asserted mid-word aborts everything immediately. No frame_err is generated.

Test Plan:
- Reset values: reset_n low, random inputs -> every output 0. After release with enable=0 and 20 strobes -> word_valid stays 0.
- Basic word: enable=1, shift 0xA5C3 MSB-first with strobe period 40 cycles, word_ready=1 -> word_out=0xA5C3, word_valid high one cycle, valid appears SYNC_STAGES+2 cycles after the 16th pin edge.
- Backpressure/overflow: word_ready=0, send 0x1234 then 0xBEEF -> word_out stays 0x1234 and overflow=1. Pulse overflow_clr -> overflow=0. Raise word_ready -> valid clears.
- Simultaneous accept: hold 0x1111 valid, complete 0x2222 in the same cycle as word_ready=1 -> word_out=0x2222, word_valid stays 1, overflow=0.
- Enable drop: 7 bits, then enable low -> frame_err single pulse, busy=0. Re-enable and send 0x00FF -> word_out=0x00FF (no stale bits).
- Timeout: 5 bits, then no strobe for TIMEOUT_CYC cycles -> frame_err pulse exactly once, busy=0. Next full word 0x8001 received correctly.

Source files
------------

// File: rtl/rpi_strobe_rx_if.sv
// Word stream from the Pi strobe receiver to downstream audio logic.
// The master presents word_out/word_valid and the slave returns word_ready.
interface rpi_strobe_rx_if #(
  parameter int unsigned WORD_W = 16
);
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/rpi_strobe_rx.sv
// Pi-to-FPGA strobe receiver: synchronises strobe/data/enable from GPIO, shifts in
// MSB-first words on strobe rising edges and offers them on a valid/ready stream.
module rpi_strobe_rx #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             rpi_clk,
  input  logic             rpi_data,
  input  logic             rpi_enable,
  rpi_strobe_rx_if.master  word_if,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WORD_W + 1);
  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_W - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StDisabled, StArmed, StRecv} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic                   clk_prev_q;
  logic                   rise_q;
  logic                   data_q;
  logic                   en_q;

  state_e            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [CntW-1:0]   cnt_q;
  logic [TmoW-1:0]   tmo_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              overflow_q;
  logic              frame_err_q;

  logic [WORD_W-1:0] shift_nxt;
  logic              complete;
  logic              tmo_hit;

  // Edge detect is registered so rise, data and enable reach the FSM aligned.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      en_sync_q   <= '0;
      clk_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      data_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], rpi_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], rpi_data};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], rpi_enable};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      rise_q      <= clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
      data_q      <= data_sync_q[SYNC_STAGES-1];
      en_q        <= en_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    shift_nxt = {shift_q[WORD_W-2:0], data_q};
    complete  = (state_q == StRecv) && en_q && rise_q && (cnt_q == LastCnt);
    tmo_hit   = (tmo_q == TmoLast);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StDisabled;
      shift_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      // A completion lands in word_out if the slot is empty or being drained now.
      if (complete) begin
        if (!valid_q || word_if.word_ready) begin
          word_q  <= shift_nxt;
          valid_q <= 1'b1;
        end
      end else if (valid_q && word_if.word_ready) begin
        valid_q <= 1'b0;
      end

      if (complete && valid_q && !word_if.word_ready) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end

      unique case (state_q)
        StDisabled: begin
          shift_q <= '0;
          cnt_q   <= '0;
          tmo_q   <= '0;
          if (en_q) state_q <= StArmed;
        end
        StArmed: begin
          tmo_q <= '0;
          if (!en_q) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= StDisabled;
          end else if (rise_q) begin
            shift_q <= shift_nxt;
            cnt_q   <= CntW'(1);
            state_q <= StRecv;
          end
        end
        StRecv: begin
          if (!en_q) begin
            // Enable wins over a coincident strobe edge.
            frame_err_q <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            state_q     <= StDisabled;
          end else if (rise_q) begin
            tmo_q <= '0;
            if (complete) begin
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= StArmed;
            end else begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_q + CntW'(1);
            end
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            state_q     <= StArmed;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        default: state_q <= StDisabled;
      endcase
    end
  end

  assign word_if.word_out   = word_q;
  assign word_if.word_valid = valid_q;
  assign overflow           = overflow_q;
  assign frame_err          = frame_err_q;
  assign busy               = (state_q == StRecv);

endmodule
